// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target write-path receiver.
package i2c_pkg;

  localparam int   I2C_ADDR_W = 7;
  localparam int   I2C_BYTE_W = 8;
  localparam logic RW_WRITE   = 1'b0;
  localparam int   HOLD_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_DATA, ST_DATA_ACK, ST_IGNORE
  } t_target_state;

  // Sub-steps of the ninth (acknowledge) clock, shared by address and data ACK.
  typedef enum logic [2:0] {
    AP_WAIT_FALL8, AP_HOLD_DRIVE, AP_STRETCH, AP_HOLD_SCL, AP_WAIT_FALL9, AP_HOLD_RELEASE
  } t_ack_phase;

  typedef struct packed {
    t_target_state         state;
    t_ack_phase            phase;
    logic [3:0]            bit_cnt;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [I2C_BYTE_W-1:0] shift;
    logic [I2C_BYTE_W-1:0] data;
    logic                  valid;
    logic                  held;
    logic                  addressed;
    logic                  sda_drive;
    logic                  scl_drive;
    logic                  start;
    logic                  stop;
    logic                  overrun;
  } t_rx_regs;

  localparam t_rx_regs RX_RESET = '{
    state: ST_IDLE, phase: AP_WAIT_FALL8, bit_cnt: '0, hold_cnt: '0, shift: '0, data: '0,
    valid: 1'b0, held: 1'b0, addressed: 1'b0, sda_drive: 1'b1, scl_drive: 1'b1,
    start: 1'b0, stop: 1'b0, overrun: 1'b0
  };

  function automatic logic addr_match(input logic [I2C_BYTE_W-1:0] b,
                                      input logic [I2C_ADDR_W-1:0] addr);
    return (b[I2C_BYTE_W-1:1] == addr) && (b[0] == RW_WRITE);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises the SDA/SCL pad senses and derives SCL edge and START/STOP strobes.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sda_i,
  input  logic scl_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] sda_sync_q, scl_sync_q;
  logic sda_hist_q, scl_hist_q;
  logic sda_s, scl_s, sda_rise, sda_fall;

  // Lines reset to the idle (released, high) level so reset never fakes an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sda_sync_q <= '1;
      scl_sync_q <= '1;
      sda_hist_q <= 1'b1;
      scl_hist_q <= 1'b1;
    end else begin
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_hist_q <= sda_s;
      scl_hist_q <= scl_s;
    end
  end

  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_rise   = sda_s & ~sda_hist_q;
  assign sda_fall   = ~sda_s & sda_hist_q;
  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_hist_q;
  assign scl_fall_o = ~scl_s & scl_hist_q;
  assign start_o    = sda_fall & scl_s & scl_hist_q;
  assign stop_o     = sda_rise & scl_s & scl_hist_q;

endmodule

// File: rtl/i2c_target_rx.sv
// I2C target write-path receiver: address match, ACK generation and byte hand-off.
// Build option I2C_TARGET_STRETCH_EN: stretch SCL on a full buffer instead of NACK + o_overrun.
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h33,
  parameter int                    SYNC_STAGES = 2,
  parameter int                    ACK_HOLD    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_sda,
  input  logic                  i_scl,
  output logic                  o_sda_drive,
  output logic                  o_scl_drive,
  output logic [I2C_BYTE_W-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_start,
  output logic                  o_stop,
  output logic                  o_addressed,
  output logic                  o_overrun
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ACK_HOLD - 1);

  logic     sda_s, scl_rise, scl_fall, start_s, stop_s;
  logic     byte_free, hold_done;
  t_rx_regs r_q, r_d;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .sda_i      (i_sda),
    .scl_i      (i_scl),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_s),
    .stop_o     (stop_s)
  );

  // A pending byte counts as gone when it is accepted this very cycle.
  assign byte_free = !r_q.valid || i_ready;
  assign hold_done = (r_q.hold_cnt == HOLD_LAST);

  function automatic t_rx_regs abort_frame(input t_rx_regs r, input t_target_state nxt);
    t_rx_regs a;
    a           = r;
    a.state     = nxt;
    a.phase     = AP_WAIT_FALL8;
    a.bit_cnt   = '0;
    a.hold_cnt  = '0;
    a.shift     = '0;
    a.held      = 1'b0;
    a.addressed = 1'b0;
    a.sda_drive = 1'b1;
    a.scl_drive = 1'b1;
    return a;
  endfunction

  // NOTE: every field gets its default from r_q before any branch, so no path infers a latch.
  always_comb begin
    r_d         = r_q;
    r_d.start   = 1'b0;
    r_d.stop    = 1'b0;
    r_d.overrun = 1'b0;
    if (r_q.valid && i_ready) r_d.valid = 1'b0;

    if (start_s) begin
      r_d       = abort_frame(r_d, ST_ADDR);
      r_d.start = 1'b1;
    end else if (stop_s) begin
      r_d      = abort_frame(r_d, ST_IDLE);
      r_d.stop = 1'b1;
    end else begin
      unique case (r_q.state)
        ST_ADDR, ST_DATA: begin
          if (r_q.bit_cnt == 4'd8) begin
            r_d.phase = AP_WAIT_FALL8;
            if (r_q.state == ST_ADDR) begin
              r_d.state = addr_match(r_q.shift, TARGET_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
            end else if (byte_free) begin
              r_d.data  = r_q.shift;
              r_d.valid = 1'b1;
              r_d.state = ST_DATA_ACK;
            end else begin
`ifdef I2C_TARGET_STRETCH_EN
              r_d.held  = 1'b1;
              r_d.state = ST_DATA_ACK;
`else
              r_d.overrun = 1'b1;
              r_d.state   = ST_IGNORE;
`endif
            end
          end else if (scl_rise) begin
            r_d.shift   = {r_q.shift[I2C_BYTE_W-2:0], sda_s};
            r_d.bit_cnt = r_q.bit_cnt + 4'd1;
          end
        end
        ST_ADDR_ACK, ST_DATA_ACK: begin
          unique case (r_q.phase)
            AP_WAIT_FALL8: if (scl_fall) begin
              r_d.phase    = AP_HOLD_DRIVE;
              r_d.hold_cnt = '0;
            end
            AP_HOLD_DRIVE: begin
              if (!hold_done) begin
                r_d.hold_cnt = r_q.hold_cnt + HOLD_W'(1);
              end else if (r_q.held) begin
                r_d.phase = AP_STRETCH;
              end else begin
                r_d.sda_drive = 1'b0;
                r_d.phase     = AP_WAIT_FALL9;
                if (r_q.state == ST_ADDR_ACK) r_d.addressed = 1'b1;
              end
            end
            AP_STRETCH: begin
              if (byte_free) begin
                r_d.data      = r_q.shift;
                r_d.valid     = 1'b1;
                r_d.held      = 1'b0;
                r_d.sda_drive = 1'b0;
                r_d.hold_cnt  = '0;
                r_d.phase     = r_q.scl_drive ? AP_WAIT_FALL9 : AP_HOLD_SCL;
              end else begin
                r_d.scl_drive = 1'b0;
              end
            end
            AP_HOLD_SCL: begin
              if (!hold_done) begin
                r_d.hold_cnt = r_q.hold_cnt + HOLD_W'(1);
              end else begin
                r_d.scl_drive = 1'b1;
                r_d.phase     = AP_WAIT_FALL9;
              end
            end
            AP_WAIT_FALL9: if (scl_fall) begin
              r_d.phase    = AP_HOLD_RELEASE;
              r_d.hold_cnt = '0;
            end
            AP_HOLD_RELEASE: begin
              if (!hold_done) begin
                r_d.hold_cnt = r_q.hold_cnt + HOLD_W'(1);
              end else begin
                r_d.sda_drive = 1'b1;
                r_d.state     = ST_DATA;
                r_d.bit_cnt   = '0;
                r_d.phase     = AP_WAIT_FALL8;
              end
            end
            default: r_d.phase = AP_WAIT_FALL8;
          endcase
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same old values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_q <= RX_RESET;
    else          r_q <= r_d;
  end

  assign o_sda_drive = r_q.sda_drive;
  assign o_data      = r_q.data;
  assign o_valid     = r_q.valid;
  assign o_start     = r_q.start;
  assign o_stop      = r_q.stop;
  assign o_addressed = r_q.addressed;
  assign o_overrun   = r_q.overrun;
`ifdef I2C_TARGET_STRETCH_EN
  assign o_scl_drive = r_q.scl_drive;
`else
  assign o_scl_drive = 1'b1;
`endif

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: a bit-level bus controller drives directed and random writes.
`timescale 1ns/1ps
module tb_i2c_target_rx;

  localparam int         SYNC_STAGES = 2;
  localparam int         ACK_HOLD    = 4;
  localparam int         H           = 20;
  localparam logic [6:0] TARGET      = 7'h33;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_ready = 1'b1;
  logic       ctrl_sda = 1'b1, ctrl_scl = 1'b1;
  logic       sda_pad, scl_pad;
  logic       o_sda_drive, o_scl_drive, o_valid, o_start, o_stop, o_addressed, o_overrun;
  logic [7:0] o_data;

  // Open-drain wired-AND of controller and target.
  assign sda_pad = ctrl_sda & o_sda_drive;
  assign scl_pad = ctrl_scl & o_scl_drive;

  i2c_target_rx #(.TARGET_ADDR(TARGET), .SYNC_STAGES(SYNC_STAGES), .ACK_HOLD(ACK_HOLD)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_sda       (sda_pad),
    .i_scl       (scl_pad),
    .o_sda_drive (o_sda_drive),
    .o_scl_drive (o_scl_drive),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_start     (o_start),
    .o_stop      (o_stop),
    .o_addressed (o_addressed),
    .o_overrun   (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  int rise_cyc = 0;
  int n_start = 0, n_stop = 0, n_over = 0, n_vrise = 0, n_sda_low = 0, n_scl_low = 0;
  int lat_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic valid_prev = 1'b0;
  int checks = 0, errors = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_start)      n_start++;
    if (o_stop)       n_stop++;
    if (o_overrun)    n_over++;
    if (!o_sda_drive) n_sda_low++;
    if (!o_scl_drive) n_scl_low++;
    if (o_valid && !valid_prev) begin
      n_vrise++;
      lat_q.push_back(cyc - rise_cyc);
    end
    if (o_valid && i_ready) got_q.push_back(o_data);
    valid_prev = o_valid;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rx(input string tag, input int base);
    check({tag, "_count"}, got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < got_q.size()) check({tag, "_byte"}, got_q[base + i], exp_q[i]);
    exp_q.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic scl_up();
    int w;
    w = 0;
    ctrl_scl = 1'b1;
    #1;
    rise_cyc = cyc;
    while (!scl_pad && w < 3000) begin
      tick(1);
      w++;
    end
    if (!scl_pad) check("scl_stretch_bound", scl_pad, 1'b1);
  endtask

  task automatic send_bit(input logic b, output logic s);
    ctrl_sda = b;
    tick(H);
    scl_up();
    tick(H);
    s = sda_pad;
    ctrl_scl = 1'b0;
    tick(H);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    ack = !s;
  endtask

  task automatic bus_start();
    ctrl_sda = 1'b1;
    tick(H);
    scl_up();
    tick(H);
    ctrl_sda = 1'b0;
    tick(H);
    ctrl_scl = 1'b0;
    tick(H);
  endtask

  task automatic bus_stop();
    ctrl_sda = 1'b0;
    tick(H);
    scl_up();
    tick(H);
    ctrl_sda = 1'b1;
    tick(H);
  endtask

  initial begin
    logic       a1, a2, a3, s;
    logic [7:0] addr, d;
    logic       ok;
    int         b0, s0, p0, v0, l0, o0, k0, c0, nb;

    // Reset values.
    tick(3);
    check("rst_sda_drive", o_sda_drive, 1'b1);
    check("rst_scl_drive", o_scl_drive, 1'b1);
    check("rst_valid", o_valid, 1'b0);
    check("rst_data", o_data, 8'h00);
    check("rst_pulses", {o_start, o_stop, o_overrun, o_addressed}, 4'b0000);
    i_rst_n = 1'b1;
    tick(5);

    // Write 0xA5 to our address.
    b0 = got_q.size(); s0 = n_start; p0 = n_stop; v0 = n_vrise; l0 = lat_q.size();
    bus_start();
    send_byte(8'h66, a1);
    check("t1_addr_ack", a1, 1'b1);
    check("t1_addressed", o_addressed, 1'b1);
    send_byte(8'hA5, a2);
    check("t1_data_ack", a2, 1'b1);
    bus_stop();
    tick(4);
    check("t1_addressed_after_stop", o_addressed, 1'b0);
    check("t1_valid_pulses", n_vrise - v0, 1);
    check("t1_start_pulses", n_start - s0, 1);
    check("t1_stop_pulses", n_stop - p0, 1);
    if (lat_q.size() > l0) check("t1_valid_latency", lat_q[l0], SYNC_STAGES + 2);
    exp_q.push_back(8'hA5);
    check_rx("t1_rx", b0);

    // Foreign address: never touched, ignores data.
    k0 = n_sda_low; v0 = n_vrise;
    bus_start();
    send_byte(8'h68, a1);
    check("t2_addr_nack", a1, 1'b0);
    check("t2_addressed", o_addressed, 1'b0);
    send_byte(8'h55, a2);
    check("t2_data_nack", a2, 1'b0);
    bus_stop();
    tick(4);
    check("t2_sda_never_driven", n_sda_low - k0, 0);
    check("t2_no_valid", n_vrise - v0, 0);

    // Own address with read bit.
    v0 = n_vrise;
    bus_start();
    send_byte(8'h67, a1);
    check("t3_read_nack", a1, 1'b0);
    check("t3_addressed", o_addressed, 1'b0);
    send_byte(8'h5A, a2);
    check("t3_ignored_data", a2, 1'b0);
    bus_stop();
    tick(4);
    check("t3_no_valid", n_vrise - v0, 0);

    // Repeated START between two writes.
    b0 = got_q.size(); s0 = n_start;
    bus_start();
    send_byte(8'h66, a1);
    send_byte(8'h12, a2);
    check("t4_acks_first", {a1, a2}, 2'b11);
    bus_start();
    send_byte(8'h66, a1);
    send_byte(8'h34, a2);
    check("t4_acks_second", {a1, a2}, 2'b11);
    bus_stop();
    tick(4);
    check("t4_start_pulses", n_start - s0, 2);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    check_rx("t4_rx", b0);

    // STOP in the middle of a data byte.
    v0 = n_vrise;
    bus_start();
    send_byte(8'h66, a1);
    check("t5_addr_ack", a1, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(logic'(i[0]), s);
    bus_stop();
    tick(4);
    check("t5_no_valid", n_vrise - v0, 0);
    check("t5_lines_released", {o_sda_drive, o_scl_drive}, 2'b11);
    check("t5_addressed", o_addressed, 1'b0);

    // Random writes against the address/ack model.
    b0 = got_q.size();
    for (int t = 0; t < 6; t++) begin
      if ($urandom_range(1, 0) == 1) addr = 8'h66;
      else begin
        addr = 8'($urandom);
        while (addr == 8'h66) addr = 8'($urandom);
      end
      ok = ((addr / 2) == 8'(TARGET)) && ((addr % 2) == 0);
      nb = $urandom_range(3, 1);
      bus_start();
      send_byte(addr, a1);
      check("rnd_addr_ack", a1, ok);
      for (int j = 0; j < nb; j++) begin
        d = 8'($urandom);
        send_byte(d, a2);
        check("rnd_data_ack", a2, ok);
        if (ok) exp_q.push_back(d);
      end
      bus_stop();
      tick(4);
    end
    check_rx("rnd_rx", b0);

    // Consumer stalled across two bytes.
    i_ready = 1'b0;
    b0 = got_q.size(); o0 = n_over; c0 = n_scl_low;
    bus_start();
    send_byte(8'h66, a1);
    send_byte(8'h11, a2);
    check("stall_first_acks", {a1, a2}, 2'b11);
`ifdef I2C_TARGET_STRETCH_EN
    fork
      send_byte(8'h22, a3);
      begin
        int w;
        w = 0;
        while (o_scl_drive && w < 2000) begin
          tick(1);
          w++;
        end
        check("stretch_scl_low", o_scl_drive, 1'b0);
        tick(40);
        check("stretch_pad_held", scl_pad, 1'b0);
        check("stretch_data_held", o_data, 8'h11);
        i_ready = 1'b1;
      end
    join
    check("stretch_ack", a3, 1'b1);
    bus_stop();
    tick(4);
    check("stretch_no_overrun", n_over - o0, 0);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    check_rx("stretch_rx", b0);
`else
    send_byte(8'h22, a3);
    check("overrun_nack", a3, 1'b0);
    check("overrun_pulse", n_over - o0, 1);
    check("overrun_first_held", {o_valid, o_data}, {1'b1, 8'h11});
    check("overrun_no_stretch", n_scl_low - c0, 0);
    i_ready = 1'b1;
    tick(4);
    bus_stop();
    tick(4);
    exp_q.push_back(8'h11);
    check_rx("overrun_rx", b0);
`endif

    // Reset while the address ACK is being driven.
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(logic'(8'h66 >> i), s);
    ctrl_sda = 1'b1;
    tick(H);
    check("reset_ack_active", o_sda_drive, 1'b0);
    i_rst_n = 1'b0;
    #1;
    check("reset_sda_released", o_sda_drive, 1'b1);
    check("reset_scl_released", o_scl_drive, 1'b1);
    check("reset_addressed", o_addressed, 1'b0);
    tick(2);
    i_rst_n = 1'b1;
    ctrl_scl = 1'b1;
    tick(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
